// File: rtl/nand_nor_pkg.sv
// Shared constants for the demux-built universal gate block.
// Default operand width used by nand_nor.
package nand_nor_pkg;

  localparam int DEF_WIDTH = 1;

endpackage

// File: rtl/nand_nor_demux.sv
// 1:2 demultiplexer cell, the only primitive the gate generator uses.
// y0 takes d when s is low, y1 takes d when s is high.
module demux1to2 (
  input  logic d,
  input  logic s,
  output logic y0,
  output logic y1
);

  assign y0 = d & ~s;
  assign y1 = d & s;

endmodule

// File: rtl/nand_nor.sv
// Per-bit NAND/NOR built only from demux1to2 cells,
// with a registered copy and valid strobe for synchronous consumers.
module nand_nor
  import nand_nor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] a_nand_b,
  output logic [WIDTH-1:0] a_nor_b,
  output logic [WIDTH-1:0] q_nand,
  output logic [WIDTH-1:0] q_nor,
  output logic             out_valid
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic not_a;
    logic not_b;
    logic and_ab;
    logic and_nn;
    logic or_ab;
    logic [6:0] spare_unused;

    demux1to2 u_not_a (
      .d (1'b1),
      .s (a[i]),
      .y0(not_a),
      .y1(spare_unused[0])
    );

    demux1to2 u_not_b (
      .d (1'b1),
      .s (b[i]),
      .y0(not_b),
      .y1(spare_unused[1])
    );

    demux1to2 u_and (
      .d (a[i]),
      .s (b[i]),
      .y0(spare_unused[2]),
      .y1(and_ab)
    );

    // OR = NOT(AND(~a, ~b)); the inner AND feeds the OR's own NOT
    demux1to2 u_or_and (
      .d (not_a),
      .s (not_b),
      .y0(spare_unused[3]),
      .y1(and_nn)
    );

    demux1to2 u_or_not (
      .d (1'b1),
      .s (and_nn),
      .y0(or_ab),
      .y1(spare_unused[4])
    );

    demux1to2 u_nand (
      .d (1'b1),
      .s (and_ab),
      .y0(a_nand_b[i]),
      .y1(spare_unused[5])
    );

    demux1to2 u_nor (
      .d (1'b1),
      .s (or_ab),
      .y0(a_nor_b[i]),
      .y1(spare_unused[6])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_nand    <= '0;
      q_nor     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        q_nand <= a_nand_b;
        q_nor  <= a_nor_b;
      end
    end
  end

endmodule

// File: tb/tb_nand_nor.sv
// Directed bench for nand_nor at WIDTH=1 and WIDTH=4:
// vector table for the gates, hand sequences for the register path.
module tb_nand_nor;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] e_nand;
    logic [3:0] e_nor;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       a1, b1, vld1;
  logic       nand1, nor1, qn1, qr1, ov1;
  logic [3:0] a4, b4;
  logic       vld4;
  logic [3:0] nand4, nor4, qn4, qr4;
  logic       ov4;

  int checks;
  int errors;
  vec_t tbl[8];

  nand_nor #(.WIDTH(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a1),
    .b        (b1),
    .in_valid (vld1),
    .a_nand_b (nand1),
    .a_nor_b  (nor1),
    .q_nand   (qn1),
    .q_nor    (qr1),
    .out_valid(ov1)
  );

  nand_nor #(.WIDTH(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a4),
    .b        (b4),
    .in_valid (vld4),
    .a_nand_b (nand4),
    .a_nor_b  (nor4),
    .q_nand   (qn4),
    .q_nor    (qr4),
    .out_valid(ov4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic qn,
                      input logic qr, input logic ov,
                      input logic en, input logic er,
                      input logic ev);
    chk({name, " q_nand"}, {3'b0, qn}, {3'b0, en});
    chk({name, " q_nor"}, {3'b0, qr}, {3'b0, er});
    chk({name, " out_valid"}, {3'b0, ov}, {3'b0, ev});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    vld1   = 1'b0;
    vld4   = 1'b0;
    a1 = 1'b0; b1 = 1'b0;
    a4 = '0;   b4 = '0;

    //           a        b        nand     nor
    tbl[0] = '{4'b0000, 4'b0000, 4'b1111, 4'b1111};
    tbl[1] = '{4'b0000, 4'b0001, 4'b1111, 4'b1110};
    tbl[2] = '{4'b0001, 4'b0000, 4'b1111, 4'b1110};
    tbl[3] = '{4'b0001, 4'b0001, 4'b1110, 4'b1110};
    tbl[4] = '{4'b0000, 4'b0001, 4'b1111, 4'b1110};
    tbl[5] = '{4'b0011, 4'b0101, 4'b1110, 4'b1000};
    tbl[6] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000};
    tbl[7] = '{4'b1010, 4'b0101, 4'b1111, 4'b0000};

    // Combinational sweep while held in reset
    for (int i = 0; i < 8; i++) begin
      a1 = tbl[i].a[0];
      b1 = tbl[i].b[0];
      a4 = tbl[i].a;
      b4 = tbl[i].b;
      #10;
      chk($sformatf("v%0d w1 nand", i), {3'b0, nand1},
          {3'b0, tbl[i].e_nand[0]});
      chk($sformatf("v%0d w1 nor", i), {3'b0, nor1},
          {3'b0, tbl[i].e_nor[0]});
      chk($sformatf("v%0d w4 nand", i), nand4, tbl[i].e_nand);
      chk($sformatf("v%0d w4 nor", i), nor4, tbl[i].e_nor);
    end

    chk1("reset w1", qn1, qr1, ov1, 1'b0, 1'b0, 1'b0);
    chk("reset w4 q_nand", qn4, 4'b0000);
    chk("reset w4 ov", {3'b0, ov4}, 4'b0000);

    // Capture 11 -> 0/0
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 1'b1; b1 = 1'b1; vld1 = 1'b1;
    @(posedge clk); #1;
    chk1("cap11", qn1, qr1, ov1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    vld1 = 1'b0;
    a1 = 1'b0; b1 = 1'b0;
    @(posedge clk); #1;
    chk1("drop vld", qn1, qr1, ov1, 1'b0, 1'b0, 1'b0);

    // Load 1/1 then async reset between edges
    @(negedge clk);
    vld1 = 1'b1;
    @(posedge clk); #1;
    chk1("cap00", qn1, qr1, ov1, 1'b1, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async rst", qn1, qr1, ov1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("first cap", qn1, qr1, ov1, 1'b1, 1'b1, 1'b1);

    // Hold: q stays 1/1 while a/b wander with in_valid low
    @(negedge clk);
    vld1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a1 = (k != 1);
      b1 = (k != 2);
      @(posedge clk); #1;
      chk1($sformatf("hold%0d", k), qn1, qr1, ov1,
           1'b1, 1'b1, 1'b0);
      chk($sformatf("hold%0d nand", k), {3'b0, nand1},
          {3'b0, (k != 0)});
      chk($sformatf("hold%0d nor", k), {3'b0, nor1}, 4'b0000);
      @(negedge clk);
    end

    // WIDTH=4 registered path
    a4 = 4'b0011; b4 = 4'b0101; vld4 = 1'b1;
    #1;
    chk("w4 pre q_nand", qn4, 4'b0000);
    chk("w4 pre ov", {3'b0, ov4}, 4'b0000);
    @(posedge clk); #1;
    chk("w4 q_nand", qn4, 4'b1110);
    chk("w4 q_nor", qr4, 4'b1000);
    chk("w4 ov", {3'b0, ov4}, 4'b0001);
    @(negedge clk);
    vld4 = 1'b0;
    a4 = 4'b1111; b4 = 4'b1111;
    @(posedge clk); #1;
    chk("w4 hold q_nand", qn4, 4'b1110);
    chk("w4 hold q_nor", qr4, 4'b1000);
    chk("w4 hold ov", {3'b0, ov4}, 4'b0000);
    chk("w4 comb nand", nand4, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
